ps2_kbd_ascii: RTL

//  PS/2 keyboard front end: receives device-to-host frames, decodes Set-2 make/break scancodes to ASCII.

---
 rtl/ps2_kbd_ascii_pkg.sv | 51 +++++
 rtl/ps2_kbd_ascii_if.sv | 25 ++
 rtl/ps2_kbd_ascii_rx_frame.sv | 95 +++++++++
 rtl/ps2_kbd_ascii.sv | 119 +++++++++++
 4 files changed

// File: rtl/ps2_kbd_ascii_pkg.sv
// rtl/ps2_kbd_ascii_pkg.sv - shared types, scancode constants and Set-2 to ASCII map
// Package kbd_pkg: event codes, prefix/shift scancodes, decoder FSM states,
// sc_to_ascii() returning 8'h00 for keys that have no mapping.
// Optional feature macro: KBD_SHIFT_EN (the shift argument only matters when it is set).
package kbd_pkg;

  typedef enum logic [1:0] {
    KBD_NONE    = 2'b00,
    KBD_PRESS   = 2'b01,
    KBD_RELEASE = 2'b10,
    KBD_REPEAT  = 2'b11
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  // 8'h00 means "unmapped"; no mapped key produces NUL.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    // Only letters are affected by shift.
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/ps2_kbd_ascii_if.sv
// rtl/ps2_kbd_ascii_if.sv - keyboard pins and decoded event bundle
// ps2_clk/ps2_data : raw PS/2 lines from the keyboard (asynchronous)
// kbd_ascii        : ASCII of last event key
// state            : one-cycle event code (none/press/release/repeat)
// scan_code        : last accepted raw byte
// frame_err        : one-cycle pulse on a dropped frame
// master = keyboard/consumer side, slave = ps2_kbd_ascii.
interface ps2_kbd_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] kbd_ascii;
  logic [1:0] state;
  logic [7:0] scan_code;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  kbd_ascii, state, scan_code, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output kbd_ascii, state, scan_code, frame_err
  );
endinterface

// File: rtl/ps2_kbd_ascii_rx_frame.sv
// rtl/ps2_kbd_ascii_rx_frame.sv - PS/2 device-to-host frame receiver (module ps2_rx_frame)
// Ports: clk, clrn (async active-low), ps2_clk/ps2_data (raw, async),
//        data_byte (last good byte), byte_valid (1-cycle), frame_err (1-cycle).
// Frame: start 0, D0..D7 LSB first, odd parity, stop 1; sampled on the
// synchronized ps2_clk falling edge. A stalled partial frame is discarded
// after TIMEOUT_CYCLES idle cycles.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   din;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par;
  logic [TW-1:0]          tcnt;

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = dat_sync[SYNC_STAGES-1];

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      par        <= 1'b0;
      tcnt       <= '0;
      data_byte  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (din) frame_err <= 1'b1;
          else     bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {din, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= din;
          bit_cnt <= 4'd10;
        end else begin
          // Stop bit: data plus parity must hold an odd number of ones.
          bit_cnt <= 4'd0;
          if (din && (^{shreg, par})) begin
            data_byte  <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= 4'd0;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_ascii.sv
// rtl/ps2_kbd_ascii.sv - PS/2 keyboard front end: Set-2 make/break to ASCII events
// Ports: clk, clrn (async active-low), kbd (ps2_kbd_ascii_if.slave:
//        ps2_clk, ps2_data in; kbd_ascii, state, scan_code, frame_err out).
// Latency: stop bit sampled in cycle N -> event on state in N+2.
// Optional macro KBD_SHIFT_EN: either shift key held turns letters uppercase.
module ps2_kbd_ascii
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic           clk,
  input  logic           clrn,
  ps2_kbd_ascii_if.slave kbd
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (kbd.ps2_clk),
    .ps2_data  (kbd.ps2_data),
    .data_byte (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  dec_state_t dec;
  kbd_state_t state_r;
  logic [7:0] ascii_r;
  logic [7:0] scan_r;
  logic [7:0] held_code;
  logic       shift_held;
  logic [7:0] ascii;
  logic       mapped;

`ifdef KBD_SHIFT_EN
  logic shift_l;
  logic shift_r;
  assign shift_held = shift_l | shift_r;
`else
  assign shift_held = 1'b0;
`endif

  assign ascii  = sc_to_ascii(rx_byte, shift_held);
  assign mapped = (ascii != 8'h00);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dec       <= DEC_IDLE;
      state_r   <= KBD_NONE;
      ascii_r   <= 8'h00;
      scan_r    <= 8'h00;
      held_code <= 8'h00;
`ifdef KBD_SHIFT_EN
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
`endif
    end else begin
      state_r <= KBD_NONE;
      if (rx_valid) begin
        scan_r <= rx_byte;
        case (dec)
          DEC_IDLE: begin
            if (rx_byte == SC_BREAK) begin
              dec <= DEC_BRK;
            end else if (rx_byte == SC_EXT) begin
              dec <= DEC_EXT;
`ifdef KBD_SHIFT_EN
            end else if (rx_byte == SC_LSHIFT) begin
              shift_l <= 1'b1;
            end else if (rx_byte == SC_RSHIFT) begin
              shift_r <= 1'b1;
`endif
            end else if (mapped) begin
              ascii_r <= ascii;
              if (rx_byte == held_code) begin
                state_r <= KBD_REPEAT;
              end else begin
                state_r   <= KBD_PRESS;
                held_code <= rx_byte;
              end
            end
          end
          DEC_BRK: begin
            dec <= DEC_IDLE;
`ifdef KBD_SHIFT_EN
            if (rx_byte == SC_LSHIFT) begin
              shift_l <= 1'b0;
            end else if (rx_byte == SC_RSHIFT) begin
              shift_r <= 1'b0;
            end else
`endif
            if (mapped) begin
              state_r <= KBD_RELEASE;
              ascii_r <= ascii;
              if (rx_byte == held_code) held_code <= 8'h00;
            end
          end
          // Extended keys (arrows etc.) are swallowed without events.
          DEC_EXT: dec <= (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
          default: dec <= DEC_IDLE;
        endcase
      end
    end
  end

  assign kbd.kbd_ascii = ascii_r;
  assign kbd.state     = state_r;
  assign kbd.scan_code = scan_r;
  assign kbd.frame_err = rx_err;

endmodule
